req_encoder_4to2: RTL
=====================

Name: req_encoder_4to2

Overview:
- Sequential 4-to-2 encoder: the encode-direction counterpart of the team's 2-to-4 enable decoder.
- Captures one-hot or multi-hot request pulses into a pending register.
- Presents one encoded index at a time on a valid/ready output.
- Clears each request once it is accepted. Sits between event sources (button/interrupt lines) and any index-consuming logic.

Parameters:
- N, 4, number of request lines.
- W, 2, index width; must equal clog2(N).
- RR, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when 0, new requests are ignored
- req  input  N  request lines, sampled every clock edge while en=1
- ready  input  1  consumer accepts out_idx this cycle
- out_valid  output  1  out_idx holds a valid claimed request
- out_idx  output  W  encoded index of the claimed request
- pending  output  N  registered pending bitmap (excludes the presented entry)
- ovf  output  1  one-cycle pulse: a request was merged into an already-pending bit

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, out_valid=0, out_idx=0, ovf=0.
  - RR pointer=N-1, so the first round-robin search starts at index 0.
- Capture:
  - pending_next = (pending & ~claim) | (en ? req : 0).
  - A set wins over a claim-clear on the same bit in the same cycle; the new request stays pending as a fresh event.
- ovf: asserted in the cycle after an edge where, for some bit i, en & req[i] & pending[i] & ~claim[i] held. It is a pulse, not sticky.
- Output state machine, two states:
  - IDLE (out_valid=0): if pending!=0, pick index p, load out_idx=p, set out_valid=1, set claim=onehot(p) → PRESENT. Otherwise stay in IDLE.
  - PRESENT (out_valid=1), ready=0: hold out_idx stable; claim=0.
  - PRESENT, ready=1, pending!=0: pick the next p, load it, remain in PRESENT. This gives back-to-back throughput of one index per cycle.
  - PRESENT, ready=1, pending==0: out_valid=0 → IDLE.
- Picking:
  - RR=0: highest set index.
  - RR=1: first set bit searching upward from (ptr+1) mod N with wrap-around. ptr updates to p only on a claim.
- Latency: req sampled at edge t0 reaches pending after t0. With the output stage free, out_valid=1 and out_idx are visible after edge t0+1.
- The presented entry is not in pending, so a re-request of the same index while it is presented sets pending again (a second event). It does not raise ovf.
- en=0 masks capture only. Pending entries keep draining and out_valid behaviour is unchanged.
- ready while out_valid=0 is ignored.
- Reset mid-operation: all state clears immediately and asynchronously. Pending and presented requests are lost, with no ovf.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package enc_pkg holds:
  - N and W defaults.
  - The RR mode constants (MODE_FIXED=0, MODE_RR=1).
  - The state encoding localparams (S_IDLE, S_PRESENT).
- One combinational sub-module, req_pick: inputs are the bitmap, ptr and mode; outputs are a found flag and index p. It is reusable by later arbiters.
- The top level holds the pending register, the FSM, the pointer and ovf.

Test Plan:
- Reset then idle: rst_n low mid-cycle, with req=4'b1010 pending → out_valid=0, pending=0 asynchronously; after release with req=0 → nothing presented.
- Fixed priority burst: RR=0, single-cycle req=4'b1011, ready=1 → out_idx sequence 3, 1, 0 on three consecutive cycles, starting 2 edges after capture; then out_valid=0.
- Backpressure: RR=0, req=4'b0100, ready=0 for 5 cycles → out_idx=2 held stable with out_valid=1; ready=1 for one cycle → out_valid=0 next cycle.
- Round-robin fairness: RR=1, req held 4'b1111 with ready=1 → out_idx cycles 0, 1, 2, 3, 0, 1…; with req=4'b1001 held → 0, 3, 0, 3.
- Overflow and merge: req[1] pulsed while pending[1]=1 and out_idx=3 is held by backpressure → ovf=1 for exactly one cycle; index 1 is presented only once.
- Enable and set-vs-claim: en=0 with req=4'b0001 → never captured. en=1, req[2] asserted in the claim cycle of index 2 → index 2 is presented twice.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for request encoders/arbiters: default sizes, pick modes, FSM states.
package enc_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned W_DEF      = 2;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/req_pick.sv
// Combinational picker: highest set bit (fixed) or first set bit above ptr with wrap (round-robin).
module req_pick
  import enc_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic [N-1:0] bitmap,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         found,
  output logic [W-1:0] p
);

  logic         hit;
  logic [W-1:0] cand;

  always_comb begin
    found = |bitmap;
    p     = '0;
    hit   = 1'b0;
    cand  = '0;
    if (mode == 1'(MODE_RR)) begin
      // Walk ptr+1, ptr+2, ... wrapping at N; first hit wins.
      for (int k = 1; k <= int'(N); k++) begin
        cand = W'((int'(ptr) + k) % int'(N));
        if (!hit && bitmap[cand]) begin
          p   = cand;
          hit = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (bitmap[i]) p = W'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder_4to2.sv
// Sequential request encoder: captures request pulses into a pending map and
// presents one claimed index at a time on a valid/ready output.
module req_encoder_4to2
  import enc_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned W  = W_DEF,
  parameter int unsigned RR = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         ovf
);

  localparam logic PICK_MODE = (RR == MODE_RR);

  state_t       state, state_nx;
  logic [W-1:0] idx_nx;
  logic [W-1:0] ptr, ptr_nx;
  logic [N-1:0] claim_c;
  logic [N-1:0] capture_c;
  logic [N-1:0] pending_nx;
  logic         ovf_nx;
  logic         found_c;
  logic [W-1:0] pick_c;

  req_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .bitmap (pending),
    .ptr    (ptr),
    .mode   (PICK_MODE),
    .found  (found_c),
    .p      (pick_c)
  );

  // Next-state: claim a pending entry whenever the output slot is free or being accepted.
  always_comb begin
    state_nx = state;
    idx_nx   = out_idx;
    ptr_nx   = ptr;
    claim_c  = '0;
    case (state)
      S_IDLE: begin
        if (found_c) begin
          idx_nx          = pick_c;
          claim_c[pick_c] = 1'b1;
          state_nx        = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ready) begin
          if (found_c) begin
            idx_nx          = pick_c;
            claim_c[pick_c] = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
    endcase
    if (|claim_c) ptr_nx = pick_c;
    // A fresh set overrides a same-cycle claim-clear; merging into a live bit is an overflow.
    capture_c  = en ? req : '0;
    pending_nx = (pending & ~claim_c) | capture_c;
    ovf_nx     = |(capture_c & pending & ~claim_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= '0;
      out_idx <= '0;
      ptr     <= W'(N - 1);
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      out_idx <= idx_nx;
      ptr     <= ptr_nx;
      ovf     <= ovf_nx;
    end
  end

  assign out_valid = (state == S_PRESENT);

endmodule
